// File: rtl/capt_sched.sv
// -----------------------------------------------------------------------------
// capt_sched
//   Round-robin scheduler that shares one capture-slot counter between N_REQ
//   requesters. Each cycle it grants at most one requester and issues the
//   matching capture strobe. Once DEPTH slots are occupied, it stops granting
//   and holds drain_req high until the downstream consumer acknowledges the
//   drain.
//
// Ports
//   clock      in   system clock, all state updates on the rising edge
//   rst_n      in   synchronous reset, active-low
//   en         in   granting allowed while filling
//   clr        in   synchronous flush of slot count (any state)
//   req        in   level requests, held until the matching gnt bit is seen
//   drain_ack  in   consumer has emptied the slots (only looked at in HOLD)
//   gnt        out  registered one-hot grant, one-cycle pulse
//   capture    out  registered capture strobe, high exactly when gnt != 0
//   count      out  registered number of occupied slots
//   full       out  registered, high iff count == DEPTH
//   drain_req  out  high while waiting for drain_ack
//   busy       out  high when slots are occupied or a drain is pending
// -----------------------------------------------------------------------------
module capt_sched #(
   parameter int N_REQ = 4,
   parameter int DEPTH = 6,
   parameter int CNT_W = 3
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic [N_REQ-1:0] req,
   input  logic             drain_ack,
   output logic [N_REQ-1:0] gnt,
   output logic             capture,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             drain_req,
   output logic             busy
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int SUM_W = PTR_W + 1;

   typedef enum logic [1:0] {
      ST_FILL = 2'b00,
      ST_HOLD = 2'b01
   } state_t;

   state_t             state_q;
   logic [PTR_W-1:0]   ptr_q;
   logic [N_REQ-1:0]   gnt_q;
   logic               capture_q;
   logic [CNT_W-1:0]   count_q;
   logic               full_q;

   logic [N_REQ-1:0]   elig_d;
   logic               win_found_d;
   logic [PTR_W-1:0]   win_idx_d;
   logic [N_REQ-1:0]   gnt_d;
   logic [CNT_W-1:0]   count_d;
   logic               full_d;

   // Requester index k positions after ptr, wrapped modulo N_REQ.
   function automatic logic [PTR_W-1:0] rr_index(input logic [PTR_W-1:0] ptr, input int k);
      logic [SUM_W-1:0] sum;
      logic [SUM_W-1:0] wrapped;
      sum     = {1'b0, ptr} + SUM_W'(k);
      wrapped = (sum >= SUM_W'(N_REQ)) ? (sum - SUM_W'(N_REQ)) : sum;
      return wrapped[PTR_W-1:0];
   endfunction

   // Round-robin winner search and next-value computation for a grant.
   always_comb begin
      // The requester granted this cycle is masked so nobody wins twice in a row.
      elig_d      = req & ~gnt_q;
      win_found_d = 1'b0;
      win_idx_d   = ptr_q;
      // Search from the far end back so the closest candidate after ptr wins.
      for (int k = N_REQ; k >= 1; k--) begin
         if (elig_d[rr_index(ptr_q, k)]) begin
            win_found_d = 1'b1;
            win_idx_d   = rr_index(ptr_q, k);
         end else begin
            win_found_d = win_found_d;
            win_idx_d   = win_idx_d;
         end
      end
      gnt_d   = N_REQ'(1) << win_idx_d;
      count_d = count_q + CNT_W'(1);
      full_d  = (count_d == CNT_W'(DEPTH));
   end

   // Fill/hold sequencer with all outputs registered.
   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q   <= ST_FILL;
         ptr_q     <= PTR_W'(N_REQ - 1);
         gnt_q     <= '0;
         capture_q <= 1'b0;
         count_q   <= '0;
         full_q    <= 1'b0;
      end else if (clr) begin
         // Flush keeps ptr so round-robin fairness survives the flush.
         state_q   <= ST_FILL;
         gnt_q     <= '0;
         capture_q <= 1'b0;
         count_q   <= '0;
         full_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_FILL: begin
               if (en && win_found_d) begin
                  gnt_q     <= gnt_d;
                  capture_q <= 1'b1;
                  count_q   <= count_d;
                  ptr_q     <= win_idx_d;
                  full_q    <= full_d;
                  state_q   <= full_d ? ST_HOLD : ST_FILL;
               end else begin
                  gnt_q     <= '0;
                  capture_q <= 1'b0;
               end
            end
            ST_HOLD: begin
               // Requests are ignored here and are not queued.
               gnt_q     <= '0;
               capture_q <= 1'b0;
               if (drain_ack) begin
                  count_q <= '0;
                  full_q  <= 1'b0;
                  state_q <= ST_FILL;
               end else begin
                  state_q <= ST_HOLD;
               end
            end
            default: begin
               state_q   <= ST_FILL;
               gnt_q     <= '0;
               capture_q <= 1'b0;
            end
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign capture   = capture_q;
   assign count     = count_q;
   assign full      = full_q;
   assign drain_req = (state_q == ST_HOLD);
   assign busy      = (count_q != '0) || (state_q == ST_HOLD);

endmodule
